oled_spi_sequencer: RTL and testbench

- Sequences the byte-wide SPI master for an SSD1306 128x64 OLED.
- After reset it pulses the panel reset line, then sends a fixed 25-byte init command list.
- It then loops forever: a 6-byte address-window header (commands), followed by 1024 pixel bytes (data) pulled from an upstream valid/ready stream.
- Drives the SPI master's transmitt/data/deactivate_cs_after inputs and the panel's D/C and RES# pins.

---
 rtl/oled_spi_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_oled_spi_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : oled_spi_sequencer
// Description : Drives an SSD1306 128x64 OLED through a byte-wide SPI master.
//               It resets the panel, sends the init list, then streams frames
//               forever. Each frame is an address-window header followed by
//               pixel bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module oled_spi_sequencer #(
    parameter int RESET_CYCLES      = 16,
    parameter int RESET_WAIT_CYCLES = 16,
    parameter int FRAME_BYTES       = 1024
) (
    input  logic       clk_in,
    input  logic       reset_n_in,
    input  logic       spi_ready,
    output logic       spi_transmitt,
    output logic       spi_deactivate_cs_after,
    output logic [7:0] spi_data,
    input  logic [7:0] pix_data,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic       oled_rst_n,
    output logic       oled_dc,
    output logic       init_done,
    output logic       frame_done
);

    localparam int c_INIT_LEN = 25;
    localparam int c_HDR_LEN  = 6;
    localparam int c_IDX_MAX  = (FRAME_BYTES > c_INIT_LEN) ? FRAME_BYTES : c_INIT_LEN;
    localparam int c_IDX_W    = $clog2(c_IDX_MAX);
    localparam int c_CNT_MAX  = (RESET_CYCLES > RESET_WAIT_CYCLES) ? RESET_CYCLES : RESET_WAIT_CYCLES;
    localparam int c_CNT_W    = $clog2(c_CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_RST_LOW  = 3'd0,
        ST_RST_WAIT = 3'd1,
        ST_LOAD     = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_GUARD    = 3'd4,
        ST_WAIT     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PH_INIT = 2'd0,
        PH_HDR  = 2'd1,
        PH_PIX  = 2'd2
    } phase_t;

    state_t               r_state;
    phase_t               r_phase;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [7:0]           r_spi_data;
    logic                 r_dc;
    logic                 r_last;
    logic                 r_oled_rst_n;
    logic                 r_init_done;
    logic                 r_frame_done;

    function automatic logic [7:0] init_rom(input logic [4:0] idx);
        logic [7:0] b;
        case (idx)
            5'd0:  b = 8'hAE;  5'd1:  b = 8'hD5;  5'd2:  b = 8'h80;
            5'd3:  b = 8'hA8;  5'd4:  b = 8'h3F;  5'd5:  b = 8'hD3;
            5'd6:  b = 8'h00;  5'd7:  b = 8'h40;  5'd8:  b = 8'h8D;
            5'd9:  b = 8'h14;  5'd10: b = 8'h20;  5'd11: b = 8'h00;
            5'd12: b = 8'hA1;  5'd13: b = 8'hC8;  5'd14: b = 8'hDA;
            5'd15: b = 8'h12;  5'd16: b = 8'h81;  5'd17: b = 8'hCF;
            5'd18: b = 8'hD9;  5'd19: b = 8'hF1;  5'd20: b = 8'hDB;
            5'd21: b = 8'h40;  5'd22: b = 8'hA4;  5'd23: b = 8'hA6;
            5'd24: b = 8'hAF;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Column window 0..127, page window 0..7: the full panel every frame.
    function automatic logic [7:0] hdr_rom(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0: b = 8'h21;  3'd1: b = 8'h00;  3'd2: b = 8'h7F;
            3'd3: b = 8'h22;  3'd4: b = 8'h00;  3'd5: b = 8'h07;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    logic w_init_last;
    logic w_hdr_last;
    logic w_pix_last;

    assign w_init_last = (r_idx == c_IDX_W'(c_INIT_LEN - 1));
    assign w_hdr_last  = (r_idx == c_IDX_W'(c_HDR_LEN - 1));
    assign w_pix_last  = (r_idx == c_IDX_W'(FRAME_BYTES - 1));

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state      <= ST_RST_LOW;
            r_phase      <= PH_INIT;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_spi_data   <= 8'h00;
            r_dc         <= 1'b0;
            r_last       <= 1'b0;
            r_oled_rst_n <= 1'b0;
            r_init_done  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_RST_LOW: begin
                    if (r_cnt == c_CNT_W'(RESET_CYCLES - 1)) begin
                        r_cnt        <= '0;
                        r_oled_rst_n <= 1'b1;
                        r_state      <= ST_RST_WAIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RST_WAIT: begin
                    if (r_cnt == c_CNT_W'(RESET_WAIT_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_phase <= PH_INIT;
                        r_idx   <= '0;
                        r_state <= ST_LOAD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_LOAD: begin
                    case (r_phase)
                        PH_INIT: begin
                            r_spi_data <= init_rom(r_idx[4:0]);
                            r_dc       <= 1'b0;
                            r_last     <= w_init_last;
                            r_state    <= ST_ISSUE;
                        end
                        PH_HDR: begin
                            r_spi_data <= hdr_rom(r_idx[2:0]);
                            r_dc       <= 1'b0;
                            r_last     <= w_hdr_last;
                            r_state    <= ST_ISSUE;
                        end
                        PH_PIX: begin
                            // A stalled stream parks here; CS stays asserted mid-frame.
                            if (pix_valid) begin
                                r_spi_data <= pix_data;
                                r_dc       <= 1'b1;
                                r_last     <= w_pix_last;
                                r_state    <= ST_ISSUE;
                            end
                        end
                        default: r_phase <= PH_INIT;
                    endcase
                end
                ST_ISSUE: begin
                    if (spi_ready) begin
                        r_state <= ST_GUARD;
                    end
                end
                ST_GUARD: begin
                    // The master still shows ready this cycle; don't mistake it for completion.
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (spi_ready) begin
                        r_state <= ST_LOAD;
                        case (r_phase)
                            PH_INIT: begin
                                if (w_init_last) begin
                                    r_init_done <= 1'b1;
                                    r_phase     <= PH_HDR;
                                    r_idx       <= '0;
                                end else begin
                                    r_idx <= r_idx + 1'b1;
                                end
                            end
                            PH_HDR: begin
                                if (w_hdr_last) begin
                                    r_phase <= PH_PIX;
                                    r_idx   <= '0;
                                end else begin
                                    r_idx <= r_idx + 1'b1;
                                end
                            end
                            PH_PIX: begin
                                if (w_pix_last) begin
                                    r_frame_done <= 1'b1;
                                    r_phase      <= PH_HDR;
                                    r_idx        <= '0;
                                end else begin
                                    r_idx <= r_idx + 1'b1;
                                end
                            end
                            default: r_phase <= PH_INIT;
                        endcase
                    end
                end
                default: r_state <= ST_RST_LOW;
            endcase
        end
    end

    assign spi_transmitt           = (r_state == ST_ISSUE) && spi_ready;
    assign pix_ready               = (r_state == ST_LOAD) && (r_phase == PH_PIX);
    assign spi_data                = r_spi_data;
    assign oled_dc                 = r_dc;
    assign spi_deactivate_cs_after = r_last;
    assign oled_rst_n              = r_oled_rst_n;
    assign init_done               = r_init_done;
    assign frame_done              = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_oled_spi_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_oled_spi_sequencer
// Description : Self-checking bench with a behavioural SPI master and a
//               byte scoreboard for oled_spi_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oled_spi_sequencer;

    localparam int c_FRAME = 4;
    localparam int c_XFER  = 6;

    logic       clk_in = 1'b0;
    logic       reset_n_in = 1'b0;
    logic       spi_ready;
    logic       spi_transmitt;
    logic       spi_deactivate_cs_after;
    logic [7:0] spi_data;
    logic [7:0] pix_data = 8'h00;
    logic       pix_valid = 1'b0;
    logic       pix_ready;
    logic       oled_rst_n;
    logic       oled_dc;
    logic       init_done;
    logic       frame_done;

    logic m_ready = 1'b1;
    logic spi_hold = 1'b0;
    assign spi_ready = m_ready && !spi_hold;

    always #5 clk_in = ~clk_in;

    oled_spi_sequencer #(
        .RESET_CYCLES     (16),
        .RESET_WAIT_CYCLES(16),
        .FRAME_BYTES      (c_FRAME)
    ) dut (
        .clk_in                 (clk_in),
        .reset_n_in             (reset_n_in),
        .spi_ready              (spi_ready),
        .spi_transmitt          (spi_transmitt),
        .spi_deactivate_cs_after(spi_deactivate_cs_after),
        .spi_data               (spi_data),
        .pix_data               (pix_data),
        .pix_valid              (pix_valid),
        .pix_ready              (pix_ready),
        .oled_rst_n             (oled_rst_n),
        .oled_dc                (oled_dc),
        .init_done              (init_done),
        .frame_done             (frame_done)
    );

    typedef struct {
        logic [7:0] data;
        logic       dc;
        logic       last;
    } sb_t;

    typedef struct {
        logic [7:0] pix;
        int         gap;
        int         hold;
        logic       exp_last;
    } vec_t;

    sb_t        exp_q[$];
    vec_t       vecs[8];
    logic [7:0] init_bytes[25];
    logic [7:0] hdr_bytes[6];

    int   n_checks = 0;
    int   n_errors = 0;
    int   frames_seen = 0;
    logic exp_init_done = 1'b0;
    logic flight_rst = 1'b0;
    logic tx_bad = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_init();
        for (int i = 0; i < 25; i++) exp_q.push_back('{init_bytes[i], 1'b0, (i == 24)});
    endtask

    task automatic push_hdr();
        for (int i = 0; i < 6; i++) exp_q.push_back('{hdr_bytes[i], 1'b0, (i == 5)});
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {spi_transmitt, spi_deactivate_cs_after, spi_data, pix_ready,
                     oled_rst_n, oled_dc, init_done, frame_done}, 32'h0);
    endtask

    // Present one pixel byte, optionally stalling the stream or the SPI master.
    task automatic drive_pix(input vec_t v);
        int         n;
        logic       bad;
        logic [7:0] sd;
        logic       sdc;
        pix_valid = 1'b0;
        n = 0;
        while (!pix_ready && n < 3000) begin n++; step(); end
        check("pix_ready_wait", pix_ready, 1'b1);
        if (v.gap > 0) begin
            sd  = spi_data;
            sdc = oled_dc;
            bad = 1'b0;
            repeat (v.gap) begin
                step();
                if (!pix_ready || spi_transmitt || spi_data !== sd || oled_dc !== sdc) bad = 1'b1;
            end
            check("pix_stall_hold", bad, 1'b0);
        end
        pix_data  = v.pix;
        pix_valid = 1'b1;
        step();
        pix_valid = 1'b0;
        exp_q.push_back('{v.pix, 1'b1, v.exp_last});
        if (v.exp_last) push_hdr();
        if (v.hold > 0) begin
            spi_hold = 1'b1;
            bad = 1'b0;
            repeat (v.hold) begin
                step();
                if (spi_transmitt) bad = 1'b1;
            end
            check("slow_spi_no_tx", bad, 1'b0);
            spi_hold = 1'b0;
            #1;
            check("slow_spi_tx_on_ready", spi_transmitt, 1'b1);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(pix_ready && exp_q.size() == 0) && n < 5000) begin n++; step(); end
        check(name, (pix_ready && exp_q.size() == 0), 1'b1);
    endtask

    always @(negedge reset_n_in) flight_rst = 1'b1;

    always @(negedge clk_in) begin
        if (frame_done) frames_seen++;
        if (spi_transmitt && !spi_ready) tx_bad = 1'b1;
    end

    // Behavioural SPI master: ready drops one cycle after acceptance.
    initial begin : spi_model
        sb_t        e;
        logic [7:0] cap_data;
        logic       cap_dc;
        logic       cap_last;
        logic       hold_bad;
        forever begin
            @(negedge clk_in);
            if (reset_n_in && spi_transmitt) begin
                flight_rst = 1'b0;
                cap_data = spi_data;
                cap_dc   = oled_dc;
                cap_last = spi_deactivate_cs_after;
                hold_bad = 1'b0;
                @(posedge clk_in); #1;
                if (!flight_rst) check("guard_no_tx", spi_transmitt, 1'b0);
                @(posedge clk_in); #1;
                m_ready = 1'b0;
                if (!flight_rst) begin
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_byte", cap_data, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte_data", cap_data, e.data);
                        check("byte_dc", cap_dc, e.dc);
                        check("byte_cs_release", cap_last, e.last);
                    end
                end
                repeat (c_XFER) begin
                    @(posedge clk_in); #1;
                    if (spi_data !== cap_data || oled_dc !== cap_dc ||
                        spi_deactivate_cs_after !== cap_last || spi_transmitt) hold_bad = 1'b1;
                end
                m_ready = 1'b1;
                @(posedge clk_in); #1;
                if (spi_data !== cap_data || oled_dc !== cap_dc ||
                    spi_deactivate_cs_after !== cap_last) hold_bad = 1'b1;
                if (!flight_rst) begin
                    check("data_hold", hold_bad, 1'b0);
                    if (!cap_dc && cap_last && cap_data == 8'hAF) exp_init_done = 1'b1;
                    check("init_done", init_done, exp_init_done);
                    check("frame_done", frame_done, (cap_dc && cap_last));
                end
            end
        end
    end

    initial begin : main
        int n;
        init_bytes = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
                       8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
                       8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
        hdr_bytes  = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
        vecs[0] = '{8'h01, 0,  0,  1'b0};
        vecs[1] = '{8'h02, 0,  0,  1'b0};
        vecs[2] = '{8'h03, 50, 0,  1'b0};
        vecs[3] = '{8'h04, 0,  0,  1'b1};
        vecs[4] = '{8'h5A, 0,  0,  1'b0};
        vecs[5] = '{8'hA5, 0,  20, 1'b0};
        vecs[6] = '{8'hFF, 0,  0,  1'b0};
        vecs[7] = '{8'h00, 3,  0,  1'b1};

        // Power-up
        push_init();
        push_hdr();
        repeat (3) step();
        check_reset_outputs("reset_outputs");
        reset_n_in = 1'b1;
        n = 0;
        while (!oled_rst_n && n < 200) begin n++; step(); end
        check("oled_rst_low_cycles", n, 16);
        n = 0;
        while (!spi_transmitt && n < 400) begin n++; step(); end
        check("first_tx_after_rise", (spi_transmitt && n >= 16), 1'b1);

        // Two frames from the vector table
        for (int i = 0; i < 8; i++) drive_pix(vecs[i]);
        wait_idle("frames_drained");
        check("frames_seen", frames_seen, 2);
        check("init_done_sticky", init_done, 1'b1);

        // Reset in the middle of pixel byte 2
        drive_pix('{8'hB0, 0, 0, 1'b0});
        drive_pix('{8'hB1, 0, 0, 1'b0});
        drive_pix('{8'hB2, 0, 0, 1'b0});
        repeat (3) step();
        #2;
        reset_n_in = 1'b0;
        #1;
        check_reset_outputs("midframe_reset_outputs");
        exp_q.delete();
        exp_init_done = 1'b0;
        push_init();
        push_hdr();
        repeat (3) step();
        check("held_in_reset", {oled_rst_n, pix_ready, init_done}, 3'b000);
        reset_n_in = 1'b1;
        wait_idle("reinit_drained");
        check("reinit_done", init_done, 1'b1);
        check("frames_after_reset", frames_seen, 2);
        check("tx_only_when_ready", tx_bad, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
